tea_stream_arbiter: RTL and testbench

- Shares one AXI4-Stream TEA crypto engine between NUM_PORT independent requester streams.
- Request path: packet-level round-robin arbitration. The grant is held from first beat to TLAST, so packets never interleave. The source port index is tagged into TID low bits.
- Response path: engine output is steered back to the originating requester by that TID tag.
- Sits between the requester masters and the engine's S_/M_ stream ports.

---
 rtl/tea_stream_arbiter.sv | 148 ++++++++++++++
 tb/tb_tea_stream_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream TEA engine between
// NUM_PORT requesters; responses are steered back by the port tag in TID.
module tea_stream_arbiter #(
    parameter int NUM_PORT           = 2,
    parameter int IDXW               = 2,
    parameter int STREAM_WIDTH_DATA  = 64,
    parameter int STREAM_WIDTH_DS    = STREAM_WIDTH_DATA / 8,
    parameter int STREAM_WIDTH_TID   = 8,
    parameter int STREAM_WIDTH_TDEST = 3
) (
    input  logic                                     ACLK,
    input  logic                                     ARESET,

    input  logic [NUM_PORT-1:0]                      rq_TVALID,
    output logic [NUM_PORT-1:0]                      rq_TREADY,
    input  logic [NUM_PORT*STREAM_WIDTH_DATA-1:0]    rq_TDATA,
    input  logic [NUM_PORT*STREAM_WIDTH_DS-1:0]      rq_TSTRB,
    input  logic [NUM_PORT*STREAM_WIDTH_DS-1:0]      rq_TKEEP,
    input  logic [NUM_PORT-1:0]                      rq_TLAST,
    input  logic [NUM_PORT*STREAM_WIDTH_TID-1:0]     rq_TID,
    input  logic [NUM_PORT*STREAM_WIDTH_TDEST-1:0]   rq_TDEST,

    output logic                                     en_TVALID,
    input  logic                                     en_TREADY,
    output logic [STREAM_WIDTH_DATA-1:0]             en_TDATA,
    output logic [STREAM_WIDTH_DS-1:0]               en_TSTRB,
    output logic [STREAM_WIDTH_DS-1:0]               en_TKEEP,
    output logic                                     en_TLAST,
    output logic [STREAM_WIDTH_TID-1:0]              en_TID,
    output logic [STREAM_WIDTH_TDEST-1:0]            en_TDEST,

    input  logic                                     de_TVALID,
    output logic                                     de_TREADY,
    input  logic [STREAM_WIDTH_DATA-1:0]             de_TDATA,
    input  logic [STREAM_WIDTH_DS-1:0]               de_TSTRB,
    input  logic [STREAM_WIDTH_DS-1:0]               de_TKEEP,
    input  logic                                     de_TLAST,
    input  logic [STREAM_WIDTH_TID-1:0]              de_TID,
    input  logic [STREAM_WIDTH_TDEST-1:0]            de_TDEST,

    output logic [NUM_PORT-1:0]                      rs_TVALID,
    input  logic [NUM_PORT-1:0]                      rs_TREADY,
    output logic [NUM_PORT*STREAM_WIDTH_DATA-1:0]    rs_TDATA,
    output logic [NUM_PORT*STREAM_WIDTH_DS-1:0]      rs_TSTRB,
    output logic [NUM_PORT*STREAM_WIDTH_DS-1:0]      rs_TKEEP,
    output logic [NUM_PORT-1:0]                      rs_TLAST,
    output logic [NUM_PORT*STREAM_WIDTH_TID-1:0]     rs_TID,
    output logic [NUM_PORT*STREAM_WIDTH_TDEST-1:0]   rs_TDEST,

    output logic [IDXW-1:0]                          grant,
    output logic                                     busy,
    output logic                                     err_tid
);

    localparam int unsigned NP  = NUM_PORT;
    localparam int unsigned DW  = STREAM_WIDTH_DATA;
    localparam int unsigned SW  = STREAM_WIDTH_DS;
    localparam int unsigned TW  = STREAM_WIDTH_TID;
    localparam int unsigned DEW = STREAM_WIDTH_TDEST;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [IDXW-1:0] last;
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] tag;
    logic            tag_ok;
    int unsigned     sel;

    // Scan last+NP down to last+1 so the final hit is the nearest port after last.
    always_comb begin
        pick = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            if (rq_TVALID[IDXW'((32'(last) + (NP - k)) % NP)])
                pick = IDXW'((32'(last) + (NP - k)) % NP);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= IDLE;
            last    <= IDXW'(NP - 1);
            grant   <= '0;
            busy    <= 1'b0;
            err_tid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|rq_TVALID) begin
                        grant <= pick;
                        state <= BUSY;
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (en_TVALID && en_TREADY && en_TLAST) begin
                        last  <= grant;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (de_TVALID && !tag_ok)
                err_tid <= 1'b1;
        end
    end

    // Request path: granted port is wired straight through while BUSY.
    always_comb begin
        sel       = 32'(grant);
        en_TVALID = (state == BUSY) && rq_TVALID[grant];
        en_TDATA  = rq_TDATA[sel*DW +: DW];
        en_TSTRB  = rq_TSTRB[sel*SW +: SW];
        en_TKEEP  = rq_TKEEP[sel*SW +: SW];
        en_TLAST  = rq_TLAST[grant];
        en_TDEST  = rq_TDEST[sel*DEW +: DEW];
        en_TID    = rq_TID[sel*TW +: TW];
        en_TID[IDXW-1:0] = grant;
        rq_TREADY = '0;
        if (state == BUSY)
            rq_TREADY[grant] = en_TREADY;
    end

    // Response path: out-of-range tags are swallowed so the engine never stalls.
    assign tag    = de_TID[IDXW-1:0];
    assign tag_ok = (32'(tag) < NP);

    always_comb begin
        rs_TVALID = '0;
        de_TREADY = 1'b1;
        if (tag_ok) begin
            rs_TVALID[tag] = de_TVALID;
            de_TREADY      = rs_TREADY[tag];
        end
    end

    assign rs_TDATA = {NUM_PORT{de_TDATA}};
    assign rs_TSTRB = {NUM_PORT{de_TSTRB}};
    assign rs_TKEEP = {NUM_PORT{de_TKEEP}};
    assign rs_TLAST = {NUM_PORT{de_TLAST}};
    assign rs_TID   = {NUM_PORT{de_TID}};
    assign rs_TDEST = {NUM_PORT{de_TDEST}};

endmodule

// File: tb/tb_tea_stream_arbiter.sv
// Directed bench for tea_stream_arbiter with per-port request queues, a
// scoreboard on the engine side and an XOR stand-in engine for loopback.
module tb_tea_stream_arbiter;

    localparam int NP  = 3;
    localparam int IW  = 2;
    localparam int DW  = 64;
    localparam int SW  = 8;
    localparam int TW  = 8;
    localparam int DEW = 3;
    localparam logic [63:0] KEY = 64'hA5C3_0F1E_5A3C_F0E1;

    logic               ACLK = 1'b0;
    logic               ARESET;
    logic [NP-1:0]      rq_TVALID, rq_TREADY, rq_TLAST;
    logic [NP*DW-1:0]   rq_TDATA;
    logic [NP*SW-1:0]   rq_TSTRB, rq_TKEEP;
    logic [NP*TW-1:0]   rq_TID;
    logic [NP*DEW-1:0]  rq_TDEST;
    logic               en_TVALID, en_TREADY, en_TLAST;
    logic [DW-1:0]      en_TDATA;
    logic [SW-1:0]      en_TSTRB, en_TKEEP;
    logic [TW-1:0]      en_TID;
    logic [DEW-1:0]     en_TDEST;
    logic               de_TVALID, de_TREADY, de_TLAST;
    logic [DW-1:0]      de_TDATA;
    logic [SW-1:0]      de_TSTRB, de_TKEEP;
    logic [TW-1:0]      de_TID;
    logic [DEW-1:0]     de_TDEST;
    logic [NP-1:0]      rs_TVALID, rs_TREADY, rs_TLAST;
    logic [NP*DW-1:0]   rs_TDATA;
    logic [NP*SW-1:0]   rs_TSTRB, rs_TKEEP;
    logic [NP*TW-1:0]   rs_TID;
    logic [NP*DEW-1:0]  rs_TDEST;
    logic [IW-1:0]      grant;
    logic               busy, err_tid;

    tea_stream_arbiter #(
        .NUM_PORT(NP), .IDXW(IW), .STREAM_WIDTH_DATA(DW), .STREAM_WIDTH_DS(SW),
        .STREAM_WIDTH_TID(TW), .STREAM_WIDTH_TDEST(DEW)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .rq_TVALID(rq_TVALID), .rq_TREADY(rq_TREADY), .rq_TDATA(rq_TDATA),
        .rq_TSTRB(rq_TSTRB), .rq_TKEEP(rq_TKEEP), .rq_TLAST(rq_TLAST),
        .rq_TID(rq_TID), .rq_TDEST(rq_TDEST),
        .en_TVALID(en_TVALID), .en_TREADY(en_TREADY), .en_TDATA(en_TDATA),
        .en_TSTRB(en_TSTRB), .en_TKEEP(en_TKEEP), .en_TLAST(en_TLAST),
        .en_TID(en_TID), .en_TDEST(en_TDEST),
        .de_TVALID(de_TVALID), .de_TREADY(de_TREADY), .de_TDATA(de_TDATA),
        .de_TSTRB(de_TSTRB), .de_TKEEP(de_TKEEP), .de_TLAST(de_TLAST),
        .de_TID(de_TID), .de_TDEST(de_TDEST),
        .rs_TVALID(rs_TVALID), .rs_TREADY(rs_TREADY), .rs_TDATA(rs_TDATA),
        .rs_TSTRB(rs_TSTRB), .rs_TKEEP(rs_TKEEP), .rs_TLAST(rs_TLAST),
        .rs_TID(rs_TID), .rs_TDEST(rs_TDEST),
        .grant(grant), .busy(busy), .err_tid(err_tid)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic [7:0]  tid;
        logic [2:0]  dest;
        int          gap;
    } beat_t;

    beat_t txq [NP][$];
    beat_t rsq [NP][$];
    beat_t expq[$];
    beat_t engq[$];

    int total = 0;
    int bad = 0;
    int en_beats = 0;
    logic [NP-1:0] hs = '0;
    logic de_hs = 1'b0;
    logic en_toggle = 1'b0;
    logic engine_on = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic smp();
        @(negedge ACLK);
        #1;
    endtask

    function automatic bit pending();
        bit r = busy || (expq.size() != 0) || (engq.size() != 0);
        for (int p = 0; p < NP; p++)
            r = r || (txq[p].size() != 0) || (rsq[p].size() != 0);
        return r;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            smp();
            n++;
        end
        total++;
        assert (n < budget) else begin
            bad++;
            $error("FAIL %s timeout observed=%0d cycles expected<%0d", tag, n, budget);
        end
    endtask

    task automatic add_pkt(input int p, input int n, input logic [7:0] tid,
                           input int stall_beat, input int stall_len);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom, $urandom};
            b.last = (i == n - 1);
            b.tid  = tid;
            b.dest = 3'(p);
            b.gap  = (i == stall_beat) ? stall_len : 0;
            txq[p].push_back(b);
            b.gap = 0;
            b.tid = {tid[7:2], 2'(p)};
            expq.push_back(b);
            if (engine_on) begin
                b.data = b.data ^ KEY;
                rsq[p].push_back(b);
            end
        end
    endtask

    // Stimulus driver: advances queues on handshakes sampled at the preceding negedge.
    initial begin
        rq_TVALID = '0; rq_TDATA = '0; rq_TSTRB = '1; rq_TKEEP = '1;
        rq_TLAST = '0; rq_TID = '0; rq_TDEST = '0;
        en_TREADY = 1'b1;
        de_TVALID = 1'b0; de_TDATA = '0; de_TSTRB = '1; de_TKEEP = '1;
        de_TLAST = 1'b0; de_TID = '0; de_TDEST = '0;
        rs_TREADY = '0;
        forever begin
            @(posedge ACLK);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p] && txq[p].size() > 0)
                    void'(txq[p].pop_front());
                else if (txq[p].size() > 0 && txq[p][0].gap > 0)
                    txq[p][0].gap = txq[p][0].gap - 1;
                if (txq[p].size() > 0 && txq[p][0].gap == 0) begin
                    rq_TVALID[p]          = 1'b1;
                    rq_TDATA[p*DW +: DW]  = txq[p][0].data;
                    rq_TLAST[p]           = txq[p][0].last;
                    rq_TID[p*TW +: TW]    = txq[p][0].tid;
                    rq_TDEST[p*DEW +: DEW] = txq[p][0].dest;
                end else begin
                    rq_TVALID[p] = 1'b0;
                end
            end
            en_TREADY = en_toggle ? ~en_TREADY : 1'b1;
            if (engine_on) begin
                if (de_hs && engq.size() > 0)
                    void'(engq.pop_front());
                de_TVALID = (engq.size() > 0);
                if (engq.size() > 0) begin
                    de_TDATA = engq[0].data;
                    de_TLAST = engq[0].last;
                    de_TID   = engq[0].tid;
                    de_TDEST = engq[0].dest;
                end
                rs_TREADY = NP'($urandom);
            end
        end
    end

    // Monitor: engine-side scoreboard, stand-in engine capture, response scoreboard.
    initial forever begin
        beat_t e;
        @(negedge ACLK);
        hs    = rq_TVALID & rq_TREADY;
        de_hs = de_TVALID & de_TREADY;
        if (en_TVALID && en_TREADY) begin
            en_beats++;
            total++;
            assert (expq.size() > 0) else begin
                bad++;
                $error("FAIL en_extra observed data=%h expected no beat", en_TDATA);
            end
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("en_data", en_TDATA, e.data);
                chk("en_last", 64'(en_TLAST), 64'(e.last));
                chk("en_tid", 64'(en_TID), 64'(e.tid));
                chk("en_dest", 64'(en_TDEST), 64'(e.dest));
            end
            if (engine_on)
                engq.push_back('{en_TDATA ^ KEY, en_TLAST, en_TID, en_TDEST, 0});
        end
        if (engine_on) begin
            for (int p = 0; p < NP; p++) begin
                if (rs_TVALID[p] && rs_TREADY[p]) begin
                    total++;
                    assert (rsq[p].size() > 0) else begin
                        bad++;
                        $error("FAIL rs_extra port=%0d observed data=%h expected no beat", p, rs_TDATA[p*DW +: DW]);
                    end
                    if (rsq[p].size() > 0) begin
                        e = rsq[p].pop_front();
                        chk("rs_data", rs_TDATA[p*DW +: DW], e.data);
                        chk("rs_last", 64'(rs_TLAST[p]), 64'(e.last));
                        chk("rs_tid", 64'(rs_TID[p*TW +: TW]), 64'(e.tid));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int b0;
        ARESET = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        smp();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_grant", 64'(grant), 0);
        chk("rst_err", 64'(err_tid), 0);
        chk("rst_rq_ready", 64'(rq_TREADY), 0);
        chk("rst_en_valid", 64'(en_TVALID), 0);

        // Single port, 4 beats, one arbitration cycle then TID tag 0x51.
        add_pkt(1, 4, 8'h50, -1, 0);
        smp();
        chk("arb_busy", 64'(busy), 0);
        chk("arb_en_valid", 64'(en_TVALID), 0);
        smp();
        chk("sp_busy", 64'(busy), 1);
        chk("sp_grant", 64'(grant), 1);
        chk("sp_en_tid", 64'(en_TID), 64'h51);
        chk("sp_rq_ready", 64'(rq_TREADY), 64'b010);
        repeat (3) smp();
        smp();
        chk("sp_idle_after_last", 64'(busy), 0);
        chk("sp_all_beats", 64'(expq.size()), 0);

        // Contention: expected order 0,1,0 without interleaving.
        add_pkt(0, 3, 8'h10, -1, 0);
        add_pkt(1, 3, 8'h20, -1, 0);
        add_pkt(0, 3, 8'h30, -1, 0);
        wait_idle("contention", 200);

        // Stall: last owner was 0, so port 1 wins and keeps the grant through a gap.
        add_pkt(1, 4, 8'h60, 2, 5);
        add_pkt(0, 2, 8'h70, -1, 0);
        n = 0;
        while (!(busy && !rq_TVALID[1]) && n < 40) begin
            smp();
            n++;
        end
        chk("stall_seen", 64'(n < 40), 1);
        repeat (3) begin
            chk("stall_grant", 64'(grant), 1);
            chk("stall_other_ready", 64'(rq_TREADY[0]), 0);
            chk("stall_busy", 64'(busy), 1);
            smp();
        end
        wait_idle("stall", 200);

        // en_TREADY toggling: exactly 4 transfers, order checked by the scoreboard.
        en_toggle = 1'b1;
        b0 = en_beats;
        add_pkt(0, 4, 8'h90, -1, 0);
        wait_idle("toggle", 200);
        en_toggle = 1'b0;
        chk("toggle_beats", 64'(en_beats - b0), 4);

        // Response routing driven directly.
        de_TDATA = 64'h1122_3344_5566_7788; de_TLAST = 1'b1; de_TDEST = 3'd5;
        de_TID = 8'h51; de_TVALID = 1'b1; rs_TREADY = 3'b010;
        #1;
        chk("rs_route_valid", 64'(rs_TVALID), 64'b010);
        chk("rs_route_ready", 64'(de_TREADY), 1);
        chk("rs_bcast_data", rs_TDATA[2*DW +: DW], 64'h1122_3344_5566_7788);
        chk("rs_bcast_tid", 64'(rs_TID[0 +: TW]), 64'h51);
        rs_TREADY = 3'b101;
        #1;
        chk("rs_backpressure", 64'(de_TREADY), 0);
        chk("rs_route_hold", 64'(rs_TVALID), 64'b010);
        de_TID = 8'h52;
        #1;
        chk("rs_route_p2", 64'(rs_TVALID), 64'b100);
        chk("rs_ready_p2", 64'(de_TREADY), 1);
        chk("err_before", 64'(err_tid), 0);
        de_TID = 8'h03;
        #1;
        chk("bad_tag_ready", 64'(de_TREADY), 1);
        chk("bad_tag_valid", 64'(rs_TVALID), 0);
        smp();
        chk("err_set", 64'(err_tid), 1);
        de_TVALID = 1'b0;
        smp();
        smp();
        chk("err_sticky", 64'(err_tid), 1);

        // Reset mid-packet.
        add_pkt(0, 4, 8'h80, -1, 0);
        n = 0;
        while (!busy && n < 20) begin
            smp();
            n++;
        end
        smp();
        ARESET = 1'b1;
        for (int p = 0; p < NP; p++) txq[p].delete();
        expq.delete();
        smp();
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_en_valid", 64'(en_TVALID), 0);
        chk("mid_rst_err", 64'(err_tid), 0);
        chk("mid_rst_grant", 64'(grant), 0);
        ARESET = 1'b0;
        smp();

        // Loopback through the stand-in engine: 2 ports x 16 packets.
        engine_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            add_pkt(0, 1 + int'($urandom_range(2)), 8'($urandom), -1, 0);
            add_pkt(1, 1 + int'($urandom_range(2)), 8'($urandom), -1, 0);
        end
        wait_idle("loopback", 3000);
        engine_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
